// File: rtl/latch_id_ex.sv
// ID/EX pipeline register for the 5-stage MIPS core, with the load-use hazard
// detector that stalls IF/ID and injects a bubble into EX.
module latch_id_ex #(
   parameter int NB_DATA  = 32,
   parameter int NB_REG   = 5,
   parameter int NB_ALUOP = 4
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic                i_enable,
   input  logic                i_flush,
   input  logic [NB_REG-1:0]   i_rs,
   input  logic [NB_REG-1:0]   i_rt,
   input  logic [NB_REG-1:0]   i_rd,
   input  logic [NB_DATA-1:0]  i_inm_ext,
   input  logic [NB_DATA-1:0]  i_dato_a,
   input  logic [NB_DATA-1:0]  i_dato_b,
   input  logic [NB_DATA-1:0]  i_pc_mas4,
   input  logic                i_ctrl_reg_write,
   input  logic                i_ctrl_mem_to_reg,
   input  logic                i_ctrl_mem_read,
   input  logic                i_ctrl_mem_write,
   input  logic                i_ctrl_alu_src,
   input  logic                i_ctrl_reg_dst,
   input  logic [NB_ALUOP-1:0] i_ctrl_alu_op,
   output logic [NB_REG-1:0]   o_rs,
   output logic [NB_REG-1:0]   o_rt,
   output logic [NB_REG-1:0]   o_rd,
   output logic [NB_DATA-1:0]  o_inm_ext,
   output logic [NB_DATA-1:0]  o_dato_a,
   output logic [NB_DATA-1:0]  o_dato_b,
   output logic [NB_DATA-1:0]  o_pc_mas4,
   output logic                o_ctrl_reg_write,
   output logic                o_ctrl_mem_to_reg,
   output logic                o_ctrl_mem_read,
   output logic                o_ctrl_mem_write,
   output logic                o_ctrl_alu_src,
   output logic                o_ctrl_reg_dst,
   output logic [NB_ALUOP-1:0] o_ctrl_alu_op,
   output logic                o_valid,
   output logic                o_stall
);

   logic [NB_REG-1:0]   rs_p1, rt_p1, rd_p1;
   logic [NB_DATA-1:0]  inm_p1, dato_a_p1, dato_b_p1, pc_mas4_p1;
   logic                reg_write_p1, mem_to_reg_p1, mem_read_p1;
   logic                mem_write_p1, alu_src_p1, reg_dst_p1;
   logic [NB_ALUOP-1:0] alu_op_p1;
   logic                vld_p1;
   logic                hazard;

   // A load in EX whose destination feeds the instruction in ID; $0 never hazards.
   assign hazard = i_enable & ~i_reset & vld_p1 & mem_read_p1 &
                   (rt_p1 != '0) & ((rt_p1 == i_rs) | (rt_p1 == i_rt));

   // ID -> EX stage boundary
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         rs_p1         <= '0;
         rt_p1         <= '0;
         rd_p1         <= '0;
         inm_p1        <= '0;
         dato_a_p1     <= '0;
         dato_b_p1     <= '0;
         pc_mas4_p1    <= '0;
         reg_write_p1  <= 1'b0;
         mem_to_reg_p1 <= 1'b0;
         mem_read_p1   <= 1'b0;
         mem_write_p1  <= 1'b0;
         alu_src_p1    <= 1'b0;
         reg_dst_p1    <= 1'b0;
         alu_op_p1     <= '0;
         vld_p1        <= 1'b0;
      end else if (i_enable) begin
         rs_p1      <= i_rs;
         rt_p1      <= i_rt;
         rd_p1      <= i_rd;
         inm_p1     <= i_inm_ext;
         dato_a_p1  <= i_dato_a;
         dato_b_p1  <= i_dato_b;
         pc_mas4_p1 <= i_pc_mas4;
         if (i_flush || hazard) begin
            reg_write_p1  <= 1'b0;
            mem_to_reg_p1 <= 1'b0;
            mem_read_p1   <= 1'b0;
            mem_write_p1  <= 1'b0;
            alu_src_p1    <= 1'b0;
            reg_dst_p1    <= 1'b0;
            alu_op_p1     <= '0;
            vld_p1        <= 1'b0;
         end else begin
            reg_write_p1  <= i_ctrl_reg_write;
            mem_to_reg_p1 <= i_ctrl_mem_to_reg;
            mem_read_p1   <= i_ctrl_mem_read;
            mem_write_p1  <= i_ctrl_mem_write;
            alu_src_p1    <= i_ctrl_alu_src;
            reg_dst_p1    <= i_ctrl_reg_dst;
            alu_op_p1     <= i_ctrl_alu_op;
            vld_p1        <= 1'b1;
         end
      end
   end

   assign o_rs              = rs_p1;
   assign o_rt              = rt_p1;
   assign o_rd              = rd_p1;
   assign o_inm_ext         = inm_p1;
   assign o_dato_a          = dato_a_p1;
   assign o_dato_b          = dato_b_p1;
   assign o_pc_mas4         = pc_mas4_p1;
   assign o_ctrl_reg_write  = reg_write_p1;
   assign o_ctrl_mem_to_reg = mem_to_reg_p1;
   assign o_ctrl_mem_read   = mem_read_p1;
   assign o_ctrl_mem_write  = mem_write_p1;
   assign o_ctrl_alu_src    = alu_src_p1;
   assign o_ctrl_reg_dst    = reg_dst_p1;
   assign o_ctrl_alu_op     = alu_op_p1;
   assign o_valid           = vld_p1;
   assign o_stall           = hazard;

endmodule

// File: tb/tb_latch_id_ex.sv
// Directed, table-driven bench for the ID/EX latch and its load-use stall.
module tb_latch_id_ex;

   logic        clk = 1'b0;
   logic        rst, en, fl;
   logic [4:0]  rs, rt, rd;
   logic [31:0] inm, da, db, pc;
   logic [5:0]  ctl;
   logic [3:0]  op;
   logic [4:0]  o_rs, o_rt, o_rd;
   logic [31:0] o_inm, o_da, o_db, o_pc;
   logic        o_rw, o_m2r, o_mr, o_mw, o_as, o_rdst;
   logic [3:0]  o_op;
   logic        o_valid, o_stall;
   logic [5:0]  o_ctl;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign o_ctl = {o_rw, o_m2r, o_mr, o_mw, o_as, o_rdst};

   latch_id_ex #(.NB_DATA(32), .NB_REG(5), .NB_ALUOP(4)) dut (
      .i_clk(clk), .i_reset(rst), .i_enable(en), .i_flush(fl),
      .i_rs(rs), .i_rt(rt), .i_rd(rd),
      .i_inm_ext(inm), .i_dato_a(da), .i_dato_b(db), .i_pc_mas4(pc),
      .i_ctrl_reg_write(ctl[5]), .i_ctrl_mem_to_reg(ctl[4]), .i_ctrl_mem_read(ctl[3]),
      .i_ctrl_mem_write(ctl[2]), .i_ctrl_alu_src(ctl[1]), .i_ctrl_reg_dst(ctl[0]),
      .i_ctrl_alu_op(op),
      .o_rs(o_rs), .o_rt(o_rt), .o_rd(o_rd),
      .o_inm_ext(o_inm), .o_dato_a(o_da), .o_dato_b(o_db), .o_pc_mas4(o_pc),
      .o_ctrl_reg_write(o_rw), .o_ctrl_mem_to_reg(o_m2r), .o_ctrl_mem_read(o_mr),
      .o_ctrl_mem_write(o_mw), .o_ctrl_alu_src(o_as), .o_ctrl_reg_dst(o_rdst),
      .o_ctrl_alu_op(o_op), .o_valid(o_valid), .o_stall(o_stall)
   );

   // ctl bits: {reg_write, mem_to_reg, mem_read, mem_write, alu_src, reg_dst}
   typedef struct packed {
      logic        rst, en, fl;
      logic [4:0]  rs, rt;
      logic [31:0] inm;
      logic [5:0]  ctl;
      logic [3:0]  op;
      logic        x_stall;
      logic [5:0]  x_ctl;
      logic [3:0]  x_op;
      logic        x_vld;
   } vec_t;

   localparam int NV = 21;
   vec_t vt [NV];

   logic [4:0]  e_rs, e_rt, e_rd;
   logic [31:0] e_inm, e_da, e_db, e_pc;

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s [%0d] got %h expected %h", name, idx, act, exp);
      end
   endtask

   task automatic chk_data(input int idx);
      chk("rs", idx, 32'(o_rs), 32'(e_rs));
      chk("rt", idx, 32'(o_rt), 32'(e_rt));
      chk("rd", idx, 32'(o_rd), 32'(e_rd));
      chk("inm_ext", idx, o_inm, e_inm);
      chk("dato_a", idx, o_da, e_da);
      chk("dato_b", idx, o_db, e_db);
      chk("pc_mas4", idx, o_pc, e_pc);
   endtask

   initial begin
      //            rst   en    fl    rs     rt     inm            ctl    op    stl   xctl   xop   vld
      vt[0]  = '{1'b1, 1'b1, 1'b0, 5'd5, 5'd5, 32'h0000DEAD, 6'h3F, 4'hF, 1'b0, 6'h00, 4'h0, 1'b0};
      vt[1]  = '{1'b1, 1'b1, 1'b0, 5'd5, 5'd5, 32'h0000BEEF, 6'h3F, 4'hF, 1'b0, 6'h00, 4'h0, 1'b0};
      vt[2]  = '{1'b0, 1'b1, 1'b0, 5'd1, 5'd2, 32'hFFFF8011, 6'h00, 4'h2, 1'b0, 6'h00, 4'h2, 1'b1};
      vt[3]  = '{1'b0, 1'b1, 1'b0, 5'd1, 5'd5, 32'h00000004, 6'h3A, 4'h0, 1'b0, 6'h3A, 4'h0, 1'b1};
      vt[4]  = '{1'b0, 1'b1, 1'b0, 5'd5, 5'd6, 32'h00000000, 6'h21, 4'h2, 1'b1, 6'h00, 4'h0, 1'b0};
      vt[5]  = '{1'b0, 1'b1, 1'b0, 5'd5, 5'd6, 32'h00000000, 6'h21, 4'h2, 1'b0, 6'h21, 4'h2, 1'b1};
      vt[6]  = '{1'b0, 1'b1, 1'b0, 5'd2, 5'd0, 32'h00000008, 6'h3A, 4'h0, 1'b0, 6'h3A, 4'h0, 1'b1};
      vt[7]  = '{1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 32'h00000000, 6'h21, 4'h2, 1'b0, 6'h21, 4'h2, 1'b1};
      vt[8]  = '{1'b0, 1'b1, 1'b0, 5'd1, 5'd5, 32'h0000000C, 6'h3A, 4'h0, 1'b0, 6'h3A, 4'h0, 1'b1};
      vt[9]  = '{1'b0, 1'b1, 1'b0, 5'd6, 5'd7, 32'h00000000, 6'h21, 4'h2, 1'b0, 6'h21, 4'h2, 1'b1};
      vt[10] = '{1'b0, 1'b1, 1'b1, 5'd1, 5'd2, 32'h00000011, 6'h20, 4'h2, 1'b0, 6'h00, 4'h0, 1'b0};
      vt[11] = '{1'b0, 1'b1, 1'b0, 5'd1, 5'd5, 32'h00000010, 6'h3A, 4'h0, 1'b0, 6'h3A, 4'h0, 1'b1};
      for (int k = 12; k < 17; k++)
         vt[k] = '{1'b0, 1'b0, 1'b0, 5'd5, 5'd5, 32'hA000_0000 + 32'(k), 6'h21, 4'h7, 1'b0, 6'h3A, 4'h0, 1'b1};
      vt[17] = '{1'b0, 1'b1, 1'b1, 5'd5, 5'd9, 32'h00000020, 6'h21, 4'h2, 1'b1, 6'h00, 4'h0, 1'b0};
      vt[18] = '{1'b0, 1'b1, 1'b0, 5'd5, 5'd9, 32'h00000024, 6'h21, 4'h2, 1'b0, 6'h21, 4'h2, 1'b1};
      vt[19] = '{1'b0, 1'b1, 1'b0, 5'd3, 5'd5, 32'h00000028, 6'h3A, 4'h0, 1'b0, 6'h3A, 4'h0, 1'b1};
      vt[20] = '{1'b1, 1'b1, 1'b0, 5'd5, 5'd9, 32'h0000002C, 6'h21, 4'h2, 1'b0, 6'h00, 4'h0, 1'b0};

      rst = 1'b1; en = 1'b0; fl = 1'b0; rs = '0; rt = '0; rd = '0;
      inm = '0; da = '0; db = '0; pc = '0; ctl = '0; op = '0;
      e_rs = '0; e_rt = '0; e_rd = '0; e_inm = '0; e_da = '0; e_db = '0; e_pc = '0;

      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         rst = vt[i].rst; en = vt[i].en; fl = vt[i].fl;
         rs = vt[i].rs; rt = vt[i].rt; rd = 5'(i + 3);
         inm = vt[i].inm; da = 32'h100 + 32'(i); db = 32'h200 + 32'(i); pc = 32'(4 * i);
         ctl = vt[i].ctl; op = vt[i].op;
         #1 chk("stall", i, 32'(o_stall), 32'(vt[i].x_stall));
         if (rst) begin
            e_rs = '0; e_rt = '0; e_rd = '0; e_inm = '0; e_da = '0; e_db = '0; e_pc = '0;
         end else if (en) begin
            e_rs = rs; e_rt = rt; e_rd = rd; e_inm = inm; e_da = da; e_db = db; e_pc = pc;
         end
         @(posedge clk);
         #1;
         chk("ctrl", i, 32'(o_ctl), 32'(vt[i].x_ctl));
         chk("alu_op", i, 32'(o_op), 32'(vt[i].x_op));
         chk("valid", i, 32'(o_valid), 32'(vt[i].x_vld));
         chk_data(i);
      end

      // Reset arriving while a load-use stall is active
      @(negedge clk);
      rst = 1'b0; en = 1'b1; fl = 1'b0; rs = 5'd1; rt = 5'd4; ctl = 6'h3A; op = 4'h0; inm = 32'h30;
      @(posedge clk);
      @(negedge clk);
      rs = 5'd4; rt = 5'd8; ctl = 6'h21; op = 4'h2;
      #1 chk("stall_pre_rst", 100, 32'(o_stall), 32'd1);
      rst = 1'b1;
      #1 chk("stall_in_rst", 101, 32'(o_stall), 32'd0);
      @(posedge clk);
      #1;
      chk("ctrl_rst", 102, 32'(o_ctl), 32'd0);
      chk("valid_rst", 103, 32'(o_valid), 32'd0);
      chk("inm_rst", 104, o_inm, 32'd0);
      chk("rt_rst", 105, 32'(o_rt), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
